// File: rtl/mcst_tx_pkg.sv
// Shared definitions for the Manchester transmitter: FSM states, line polarity and helpers.
// Combinational helpers only; no latency or backpressure of their own.
package mcst_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    localparam logic MCST_IDLE_LEVEL = 1'b0;
    // IEEE polarity: a 1 is low in the first half and rises mid-bit.
    localparam logic MCST_ONE_RISES  = 1'b1;

    function automatic logic first_half(input logic b);
        return b ^ MCST_ONE_RISES;
    endfunction

    function automatic logic second_half(input logic b);
        return b ^ ~MCST_ONE_RISES;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mcst_tx_if.sv
// Word-in handshake plus Manchester line and busy status of the transmitter.
// Valid/ready: a word moves on the edge where tx_valid and tx_ready are both high.
interface mcst_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              man_code;
    logic              busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  man_code,
        input  busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output man_code,
        output busy
    );
endinterface

// File: rtl/mcst_tx_tick_gen.sv
// Half-bit timer: one-cycle tick every HALF_BIT_CLKS enabled cycles; sync clear restarts the count.
// Tick is combinational from the counter; no backpressure.
module mcst_tx_tick_gen #(
    parameter int HALF_BIT_CLKS = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int            CW   = $clog2(HALF_BIT_CLKS);
    localparam logic [CW-1:0] TERM = CW'(HALF_BIT_CLKS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == TERM);

endmodule

// File: rtl/mcst_tx.sv
// Manchester transmitter: preamble then DATA_W bits MSB first, then a one-bit low gap.
// Accept-to-ready (PRE_BITS+DATA_W+1)*2*HALF_BIT_CLKS cycles; tx_ready low for the whole frame.
module mcst_tx
    import mcst_tx_pkg::*;
#(
    parameter int HALF_BIT_CLKS = 250,
    parameter int DATA_W        = 8,
    parameter int PRE_BITS      = 8
) (
    input  logic      clk,
    input  logic      rst,
    mcst_tx_if.slave  bus
);
    localparam int               IDX_W     = $clog2(max_int(PRE_BITS, DATA_W) + 1);
    localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PRE_BITS - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              half_q, half_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              man_q, man_d;
    logic              rdy_en_q;

    logic tick;
    logic accept;
    logic cur_bit;
    logic tx_ready_int;
    logic busy_int;

    assign accept = bus.tx_valid && tx_ready_int;

    mcst_tx_tick_gen #(
        .HALF_BIT_CLKS (HALF_BIT_CLKS)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (busy_int),
        .tick (tick)
    );

    // State register together with the datapath flops it sequences.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            half_q   <= 1'b0;
            shift_q  <= '0;
            man_q    <= MCST_IDLE_LEVEL;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            half_q   <= half_d;
            shift_q  <= shift_d;
            man_q    <= man_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)                                 state_d = ST_PRE;
            ST_PRE:  if (tick && half_q && idx_q == PRE_LAST)    state_d = ST_DATA;
            ST_DATA: if (tick && half_q && idx_q == DATA_LAST)   state_d = ST_GAP;
            ST_GAP:  if (tick && half_q)                         state_d = ST_IDLE;
            default:                                             state_d = ST_IDLE;
        endcase
    end

    // Preamble alternates 1,0,1,0... so its value is the inverted LSB of the index.
    assign cur_bit = (state_q == ST_PRE) ? ~idx_q[0] : shift_q[DATA_W-1];

    always_comb begin
        idx_d   = idx_q;
        half_d  = half_q;
        shift_d = shift_q;
        man_d   = man_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d = bus.tx_data;
                    idx_d   = '0;
                    half_d  = 1'b0;
                    man_d   = first_half(1'b1);
                end
            end
            ST_PRE: begin
                if (tick) begin
                    if (!half_q) begin
                        half_d = 1'b1;
                        man_d  = second_half(cur_bit);
                    end else begin
                        half_d = 1'b0;
                        if (idx_q == PRE_LAST) begin
                            idx_d = '0;
                            man_d = first_half(shift_q[DATA_W-1]);
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                            man_d = first_half(idx_q[0]);
                        end
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (!half_q) begin
                        half_d = 1'b1;
                        man_d  = second_half(cur_bit);
                    end else begin
                        half_d  = 1'b0;
                        shift_d = shift_q << 1;
                        if (idx_q == DATA_LAST) begin
                            idx_d = '0;
                            man_d = MCST_IDLE_LEVEL;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                            man_d = first_half(shift_q[DATA_W-2]);
                        end
                    end
                end
            end
            ST_GAP: begin
                man_d = MCST_IDLE_LEVEL;
                if (tick) begin
                    half_d = ~half_q;
                end
            end
            default: begin
                man_d = MCST_IDLE_LEVEL;
            end
        endcase
    end

    // rdy_en_q keeps tx_ready low until the first edge after reset release.
    always_comb begin
        tx_ready_int = (state_q == ST_IDLE) && rdy_en_q;
        busy_int     = (state_q != ST_IDLE);
    end

    assign bus.tx_ready = tx_ready_int;
    assign bus.busy     = busy_int;
    assign bus.man_code = man_q;

endmodule

// File: tb/tb_mcst_tx.sv
// Directed bench for mcst_tx with HALF_BIT_CLKS=4, DATA_W=8, PRE_BITS=4.
module tb_mcst_tx;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mcst_tx_if #(.DATA_W(8)) bus ();

    mcst_tx #(
        .HALF_BIT_CLKS (4),
        .DATA_W        (8),
        .PRE_BITS      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected half-bit levels, first half of the preamble in bit 23.
    typedef struct {
        logic [7:0]  data;
        logic [23:0] halves;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick_s();
        @(posedge clk);
        #1;
    endtask

    // Returns at #1 after the accept edge.
    task automatic send(input logic [7:0] d);
        bit ok = 1'b0;
        bit rdy_now;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            rdy_now = bus.tx_ready;
            tick_s();
            if (rdy_now) ok = 1'b1;
        end
        check("accept_seen", {31'b0, ok}, 32'd1);
    endtask

    // Called at #1 after the accept edge; returns at #1 after the ready edge (accept+104).
    task automatic run_frame(input logic [23:0] exp, input bit keep_valid,
                             input logic [7:0] nxt, input bit poke, input string tag);
        logic [3:0] lvls;
        logic [7:0] gap;
        bit         busy_all = 1'b1;
        logic       rdy_before = 1'b0;
        if (keep_valid) bus.tx_data = nxt;
        else            bus.tx_valid = 1'b0;
        for (int h = 0; h < 24; h++) begin
            for (int c = 0; c < 4; c++) begin
                lvls[3-c] = bus.man_code;
                if (bus.busy !== 1'b1) busy_all = 1'b0;
                if (poke) begin
                    bus.tx_data  = 8'($urandom);
                    bus.tx_valid = 1'($urandom_range(0, 1));
                end
                tick_s();
            end
            check($sformatf("%s_half%0d", tag, h), {28'b0, lvls}, {28'b0, {4{exp[23-h]}}});
        end
        for (int c = 0; c < 8; c++) begin
            gap[7-c] = bus.man_code;
            if (bus.busy !== 1'b1) busy_all = 1'b0;
            if (c == 7) rdy_before = bus.tx_ready;
            if (poke) begin
                bus.tx_data  = 8'($urandom);
                bus.tx_valid = 1'($urandom_range(0, 1));
            end
            tick_s();
        end
        if (!keep_valid) bus.tx_valid = 1'b0;
        check({tag, "_gap_low"},   {24'b0, gap}, 32'd0);
        check({tag, "_busy_all"},  {31'b0, busy_all}, 32'd1);
        check({tag, "_rdy_at103"}, {31'b0, rdy_before}, 32'd0);
        check({tag, "_rdy_at104"}, {31'b0, bus.tx_ready}, 32'd1);
        check({tag, "_busy_at104"}, {31'b0, bus.busy}, 32'd0);
        check({tag, "_line_at104"}, {31'b0, bus.man_code}, 32'd0);
    endtask

    initial begin
        bit quiet;

        vecs[0] = '{data: 8'hA5, halves: 24'h666699};
        vecs[1] = '{data: 8'h00, halves: 24'h66AAAA};
        vecs[2] = '{data: 8'hFF, halves: 24'h665555};
        vecs[3] = '{data: 8'h3C, halves: 24'h66A55A};
        vecs[4] = '{data: 8'h81, halves: 24'h666AA9};

        rst          = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        tick_s();
        tick_s();
        check("rst_line",  {31'b0, bus.man_code}, 32'd0);
        check("rst_busy",  {31'b0, bus.busy},     32'd0);
        check("rst_ready", {31'b0, bus.tx_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("rel_ready_before_edge", {31'b0, bus.tx_ready}, 32'd0);
        tick_s();
        check("rel_ready_after_edge", {31'b0, bus.tx_ready}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            send(vecs[i].data);
            run_frame(vecs[i].halves, 1'b0, 8'h00, 1'b0, $sformatf("vec%0d", i));
            tick_s();
        end

        // Held valid: second word accepted on the first IDLE edge.
        send(8'h00);
        run_frame(24'h66AAAA, 1'b1, 8'hFF, 1'b0, "b2b0");
        tick_s();
        check("b2b_busy_at105",  {31'b0, bus.busy},     32'd1);
        check("b2b_ready_at105", {31'b0, bus.tx_ready}, 32'd0);
        run_frame(24'h665555, 1'b0, 8'h00, 1'b0, "b2b1");

        // Valid and data churn while busy must not alter the frame or start another.
        tick_s();
        send(8'h3C);
        run_frame(24'h66A55A, 1'b0, 8'h00, 1'b1, "poke");
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy !== 1'b0 || bus.man_code !== 1'b0) quiet = 1'b0;
            tick_s();
        end
        check("poke_no_extra_frame", {31'b0, quiet}, 32'd1);

        // Reset mid-frame while the line is high.
        send(8'hA5);
        for (int i = 0; i < 5; i++) tick_s();
        check("mid_line_high", {31'b0, bus.man_code}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_line",  {31'b0, bus.man_code}, 32'd0);
        check("mid_rst_busy",  {31'b0, bus.busy},     32'd0);
        check("mid_rst_ready", {31'b0, bus.tx_ready}, 32'd0);
        bus.tx_valid = 1'b0;
        tick_s();
        tick_s();
        rst = 1'b0;
        #1;
        check("mid_rel_ready_before", {31'b0, bus.tx_ready}, 32'd0);
        tick_s();
        check("mid_rel_ready_after", {31'b0, bus.tx_ready}, 32'd1);
        check("mid_rel_busy",        {31'b0, bus.busy},     32'd0);
        send(8'h81);
        run_frame(24'h666AA9, 1'b0, 8'h00, 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
